// File: rtl/capture_engine.sv
// Logic-analyzer capture core: probe sampling at a divided rate, a pre-trigger ring FIFO,
// an edge trigger on one channel, and oldest-first valid/ready streaming of the capture.
module capture_engine #(
  parameter int SAMPLE_DIV    = 25,
  parameter int FIFO_DEPTH    = 16,
  parameter int PRE_DEPTH     = 8,
  parameter int TOTAL_SAMPLES = 304
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] probe,
  input  logic       cmd_arm,
  input  logic       cmd_reset,
  input  logic [2:0] trig_ch,
  input  logic       trig_mode,
  input  logic       debug_en,
  output logic       armed,
  output logic       captured,
  output logic       cap_start,
  output logic       overrun,
  output logic [2:0] dbg_cap_state,
  output logic [3:0] dbg_bram_count,
  output logic       dbg_trigger_edge,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       out_last
);
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int CW    = AW + 1;
  localparam int DW    = $clog2(SAMPLE_DIV);
  localparam int NPOST = TOTAL_SAMPLES - PRE_DEPTH;
  localparam int KW    = $clog2(NPOST + 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0, S_FILL = 3'd1, S_ARMED = 3'd2, S_POST = 3'd3, S_DONE = 3'd4
  } state_e;

  state_e          state_q, state_d;
  logic [7:0]      probe_s1_q, probe_s2_q, pat_q;
  logic [DW-1:0]   div_q;
  logic            prev_q, prev_vld_q, prev_vld_d;
  logic [2:0]      trig_ch_q;
  logic            trig_mode_q;
  logic [7:0]      mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_q, rd_q, wr_d, rd_d;
  logic [CW-1:0]   count_q, count_d;
  logic [KW-1:0]   collected_q, collected_d;
  logic            overrun_q, overrun_d, cap_start_q, edge_q;
  logic [7:0]      out_data_q, out_data_d, sample, head;
  logic            out_valid_q, out_valid_d, out_last_q, out_last_d;
  logic            tick, cur_bit, edge_hit, hs, flush, arm_go, push, pop, push_ok;

  assign tick     = (div_q == DW'(SAMPLE_DIV - 1));
  assign sample   = debug_en ? pat_q : probe_s2_q;
  assign cur_bit  = sample[trig_ch_q];
  // prev_vld_q keeps the first tick after arm from matching against a stale prev_q
  assign edge_hit = tick && prev_vld_q &&
                    (trig_mode_q ? (prev_q && !cur_bit) : (!prev_q && cur_bit));
  assign hs       = out_valid_q && out_ready;
  assign arm_go   = cmd_arm && !cmd_reset;
  assign flush    = cmd_arm || cmd_reset;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (cmd_reset)    state_d = S_IDLE;
    else if (cmd_arm) state_d = S_FILL;
    else begin
      case (state_q)
        S_FILL:  if (count_q == CW'(PRE_DEPTH)) state_d = S_ARMED;
        S_ARMED: if (edge_hit) state_d = S_POST;
        S_POST:  if (hs && out_last_q) state_d = S_DONE;
        default: ;
      endcase
    end
  end

  always_comb begin
    armed         = (state_q == S_FILL) || (state_q == S_ARMED);
    captured      = (state_q == S_DONE);
    dbg_cap_state = state_q;
  end

  always_comb begin
    push        = 1'b0;
    pop         = 1'b0;
    collected_d = collected_q;
    overrun_d   = overrun_q;
    prev_vld_d  = prev_vld_q || tick;
    if (!flush && tick) begin
      case (state_q)
        S_FILL:  push = (count_q < CW'(PRE_DEPTH));
        S_ARMED: begin
          push = 1'b1;
          pop  = !edge_hit;
          if (edge_hit) collected_d = KW'(1);
        end
        S_POST: if (collected_q < KW'(NPOST)) begin
          push        = 1'b1;
          collected_d = collected_q + KW'(1);
        end
        default: ;
      endcase
    end
    if (!flush && state_q == S_POST && hs) pop = 1'b1;
    // a pop in the same clk frees the slot, so a full FIFO still accepts
    push_ok = push && ((count_q != CW'(FIFO_DEPTH)) || pop);
    if (push && !push_ok) overrun_d = 1'b1;
    wr_d    = wr_q + AW'(push_ok);
    rd_d    = rd_q + AW'(pop);
    count_d = count_q + CW'(push_ok) - CW'(pop);
    if (flush) begin
      wr_d    = '0;
      rd_d    = '0;
      count_d = '0;
    end
    if (arm_go) begin
      collected_d = '0;
      overrun_d   = 1'b0;
      prev_vld_d  = 1'b0;
    end
    // output stage mirrors the post-update FIFO head; bypass when the push lands at the head
    head        = (push_ok && wr_q == rd_d) ? sample : mem[rd_d];
    out_valid_d = (state_d == S_POST) && (count_d != '0);
    out_data_d  = out_valid_d ? head : 8'h00;
    out_last_d  = out_valid_d && (collected_d == KW'(NPOST)) && (count_d == CW'(1));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      probe_s1_q  <= '0;
      probe_s2_q  <= '0;
      div_q       <= '0;
      pat_q       <= '0;
      prev_q      <= 1'b0;
      prev_vld_q  <= 1'b0;
      trig_ch_q   <= '0;
      trig_mode_q <= 1'b0;
      wr_q        <= '0;
      rd_q        <= '0;
      count_q     <= '0;
      collected_q <= '0;
      overrun_q   <= 1'b0;
      cap_start_q <= 1'b0;
      edge_q      <= 1'b0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      probe_s1_q  <= probe;
      probe_s2_q  <= probe_s1_q;
      div_q       <= tick ? '0 : div_q + DW'(1);
      if (tick) pat_q <= pat_q + 8'd1;
      if (tick && !arm_go) prev_q <= cur_bit;
      prev_vld_q  <= prev_vld_d;
      if (arm_go) begin
        trig_ch_q   <= trig_ch;
        trig_mode_q <= trig_mode;
      end
      wr_q        <= wr_d;
      rd_q        <= rd_d;
      count_q     <= count_d;
      collected_q <= collected_d;
      overrun_q   <= overrun_d;
      cap_start_q <= arm_go;
      edge_q      <= edge_hit && (state_q != S_IDLE);
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_q] <= sample;
  end

  assign cap_start        = cap_start_q;
  assign overrun          = overrun_q;
  assign dbg_bram_count   = (count_q > CW'(15)) ? 4'd15 : 4'(count_q);
  assign dbg_trigger_edge = edge_q;
  assign out_data         = out_data_q;
  assign out_valid        = out_valid_q;
  assign out_last         = out_last_q;

endmodule

// File: tb/tb_capture_engine.sv
// Directed bench for capture_engine at SAMPLE_DIV=4: trigger modes, history order,
// backpressure/overrun, debug pattern, command aborts and asynchronous reset.
module tb_capture_engine;
  logic       clk = 1'b0, rst = 1'b1;
  logic [7:0] probe = 8'hA4;
  logic       cmd_arm = 1'b0, cmd_reset = 1'b0, trig_mode = 1'b0, debug_en = 1'b0;
  logic [2:0] trig_ch = 3'd0;
  logic       out_ready = 1'b1;
  logic       armed, captured, cap_start, overrun, dbg_trigger_edge, out_valid, out_last;
  logic [2:0] dbg_cap_state;
  logic [3:0] dbg_bram_count;
  logic [7:0] out_data;

  int checks = 0, passes = 0;
  int nbeats, nlast, last_idx, nedges, bad;
  logic [7:0] cap_buf [0:511];

  capture_engine #(.SAMPLE_DIV(4), .FIFO_DEPTH(16), .PRE_DEPTH(8), .TOTAL_SAMPLES(304)) dut (
    .clk(clk), .rst(rst), .probe(probe), .cmd_arm(cmd_arm), .cmd_reset(cmd_reset),
    .trig_ch(trig_ch), .trig_mode(trig_mode), .debug_en(debug_en), .armed(armed),
    .captured(captured), .cap_start(cap_start), .overrun(overrun),
    .dbg_cap_state(dbg_cap_state), .dbg_bram_count(dbg_bram_count),
    .dbg_trigger_edge(dbg_trigger_edge), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_last(out_last)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_state(input logic [2:0] s, input int budget);
    for (int i = 0; i < budget && dbg_cap_state !== s; i++) @(negedge clk);
  endtask

  task automatic arm(input logic [2:0] ch, input logic mode);
    @(negedge clk);
    trig_ch = ch; trig_mode = mode; cmd_arm = 1'b1;
    @(negedge clk);
    cmd_arm = 1'b0;
  endtask

  task automatic run_capture(input int budget);
    nbeats = 0; nlast = 0; last_idx = -1; nedges = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (dbg_trigger_edge) nedges++;
      if (out_valid && out_ready) begin
        if (nbeats < 512) cap_buf[nbeats] = out_data;
        if (out_last) begin nlast++; last_idx = nbeats; end
        nbeats++;
      end
      if (dbg_cap_state == 3'd4 && !out_valid) break;
    end
  endtask

  initial begin
    // reset state
    clks(3);
    chk("rst_outputs", {out_valid, out_last, out_data, armed, captured, cap_start, overrun,
                        dbg_cap_state, dbg_bram_count, dbg_trigger_edge}, 0);
    rst = 1'b0;
    clks(10);
    chk("idle_state", dbg_cap_state, 0);

    // T1: rising ch0 after a long ARMED period, free-flowing writer
    arm(3'd0, 1'b0);
    chk("t1_cap_start", cap_start, 1);
    chk("t1_fill", {armed, dbg_cap_state}, {1'b1, 3'd1});
    wait_state(3'd2, 100);
    chk("t1_armed", dbg_cap_state, 2);
    chk("t1_pre_count", dbg_bram_count, 8);
    clks(80);
    chk("t1_still_armed", {dbg_cap_state, dbg_bram_count}, {3'd2, 4'd8});
    probe = 8'hA5;
    run_capture(3000);
    chk("t1_beats", nbeats, 304);
    bad = 0;
    for (int i = 0; i < 8; i++) if (cap_buf[i] !== 8'hA4) bad++;
    chk("t1_history", bad, 0);
    chk("t1_trig_byte", cap_buf[8], 8'hA5);
    chk("t1_last", {nlast, last_idx}, {32'd1, 32'd303});
    chk("t1_done", {captured, armed, dbg_cap_state}, {1'b1, 1'b0, 3'd4});
    chk("t1_edges", nedges, 1);

    // T2: falling on ch5; rising before arm and a fall during FILL must not trigger
    probe = 8'h00; clks(10);
    probe = 8'h20; clks(10);
    arm(3'd5, 1'b1);
    clks(10); probe = 8'h00;
    clks(10); probe = 8'h20;
    chk("t2_fill_ignores", dbg_cap_state, 1);
    wait_state(3'd2, 100);
    clks(40);
    chk("t2_no_false_trig", dbg_cap_state, 2);
    out_ready = 1'b0;
    probe = 8'h00;
    wait_state(3'd3, 20);
    chk("t2_post", dbg_cap_state, 3);
    clks(20);
    chk("t2_valid", out_valid, 1);

    // T5: arm mid-POST, then arm + reset together
    arm(3'd5, 1'b1);
    chk("t5_rearm", {cap_start, out_valid, dbg_cap_state}, {1'b1, 1'b0, 3'd1});
    @(negedge clk);
    chk("t5_pulse_1clk", cap_start, 0);
    @(negedge clk);
    cmd_arm = 1'b1; cmd_reset = 1'b1;
    @(negedge clk);
    cmd_arm = 1'b0; cmd_reset = 1'b0;
    chk("t5_reset_wins", {cap_start, armed, dbg_cap_state}, {1'b0, 1'b0, 3'd0});

    // T3: stalled writer overflows the FIFO, then drains to out_last
    probe = 8'h00; clks(10);
    arm(3'd0, 1'b0);
    wait_state(3'd2, 100);
    probe = 8'h01;
    wait_state(3'd3, 20);
    chk("t3_post", dbg_cap_state, 3);
    clks(60);
    chk("t3_full", {overrun, dbg_bram_count}, {1'b1, 4'd15});
    chk("t3_hold", {out_valid, out_last, out_data}, {1'b1, 1'b0, 8'h00});
    out_ready = 1'b1;
    run_capture(3000);
    chk("t3_last", {nlast, last_idx}, {32'd1, 32'(nbeats - 1)});
    chk("t3_done", {captured, overrun, dbg_cap_state}, {1'b1, 1'b1, 3'd4});

    // T4: debug pattern, trigger on ch0 rising
    debug_en = 1'b1; clks(5);
    arm(3'd0, 1'b0);
    chk("t4_overrun_clr", overrun, 0);
    run_capture(3000);
    chk("t4_beats", nbeats, 304);
    bad = 0;
    for (int i = 1; i < 304; i++) begin
      logic [7:0] nxt;
      nxt = cap_buf[i-1] + 8'd1;
      if (cap_buf[i] !== nxt) bad++;
    end
    chk("t4_consecutive", bad, 0);
    chk("t4_trig_odd", cap_buf[8][0], 1);
    chk("t4_last", {nlast, last_idx}, {32'd1, 32'd303});

    // T6: asynchronous reset mid-POST
    out_ready = 1'b0;
    arm(3'd0, 1'b0);
    wait_state(3'd3, 200);
    clks(5);
    chk("t6_valid", out_valid, 1);
    @(negedge clk);
    #2 rst = 1'b1;
    #1 chk("t6_async_clear", {out_valid, out_last, out_data, armed, captured, cap_start, overrun,
                               dbg_cap_state, dbg_bram_count, dbg_trigger_edge}, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("t6_after_release", {dbg_cap_state, out_valid}, {3'd0, 1'b0});

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
